// File: rtl/fighting_match_ctrl.sv
// Two-player fighting match controller: resolves one turn per actionEnable strobe,
// tracks health and arena positions, scores rounds and declares the match winner.
module fighting_match_ctrl #(
    parameter int HEALTH_W      = 2,
    parameter int MAX_HEALTH    = 3,
    parameter int DAMAGE        = 1,
    parameter int ARENA_LEN     = 8,
    parameter int ROUNDS_TO_WIN = 2,
    parameter int ROUND_TICKS   = 16,
    parameter int END_HOLD      = 4,
    localparam int POS_W        = $clog2(ARENA_LEN)
) (
    input  logic                clk,
    input  logic                resetGame,
    input  logic                actionEnable,
    input  logic [2:0]          action1,
    input  logic [2:0]          action2,
    output logic [HEALTH_W-1:0] health1,
    output logic [HEALTH_W-1:0] health2,
    output logic [POS_W-1:0]    pos1,
    output logic [POS_W-1:0]    pos2,
    output logic [1:0]          roundWins1,
    output logic [1:0]          roundWins2,
    output logic                firstWin,
    output logic                secondWin,
    output logic [1:0]          roundResult,
    output logic                matchOver
);

    localparam int TICK_W = $clog2(ROUND_TICKS + 1);
    localparam int HOLD_W = (END_HOLD > 1) ? $clog2(END_HOLD) : 1;

    localparam logic [HEALTH_W-1:0] HEALTH_INIT = HEALTH_W'(MAX_HEALTH);
    localparam logic [HEALTH_W-1:0] DMG         = HEALTH_W'(DAMAGE);
    localparam logic [POS_W-1:0]    POS_MAX     = POS_W'(ARENA_LEN - 1);
    localparam logic [TICK_W-1:0]   TICK_LAST   = TICK_W'(ROUND_TICKS - 1);
    localparam logic [HOLD_W-1:0]   HOLD_LAST   = HOLD_W'(END_HOLD - 1);
    localparam logic [1:0]          WINS_TARGET = 2'(ROUNDS_TO_WIN);

    localparam logic [2:0] ACT_LEFT   = 3'b001;
    localparam logic [2:0] ACT_RIGHT  = 3'b010;
    localparam logic [2:0] ACT_ATTACK = 3'b011;
    localparam logic [2:0] ACT_DEFEND = 3'b100;

    localparam logic [1:0] RES_P1   = 2'b01;
    localparam logic [1:0] RES_P2   = 2'b10;
    localparam logic [1:0] RES_DRAW = 2'b11;

    typedef enum logic [1:0] {StFight, StRoundEnd, StMatchOver} state_e;

    state_e              state;
    logic [TICK_W-1:0]   turn_cnt;
    logic [HOLD_W-1:0]   hold_cnt;

    logic                adjacent;
    logic                hit1;
    logic                hit2;
    logic [HEALTH_W-1:0] new_h1;
    logic [HEALTH_W-1:0] new_h2;
    logic [POS_W-1:0]    cand1;
    logic [POS_W-1:0]    cand2;
    logic                blocked;
    logic [POS_W-1:0]    new_p1;
    logic [POS_W-1:0]    new_p2;
    logic                ko1;
    logic                ko2;
    logic                timeout;
    logic                round_done;
    logic [1:0]          result;

    // Outcome of a turn if it were resolved this cycle; hits use pre-move positions
    always_comb begin
        adjacent = (pos2 - pos1) == POS_W'(1);
        hit1     = (action1 == ACT_ATTACK) && adjacent && (action2 != ACT_DEFEND);
        hit2     = (action2 == ACT_ATTACK) && adjacent && (action1 != ACT_DEFEND);

        new_h1 = health1;
        if (hit2) new_h1 = (health1 > DMG) ? health1 - DMG : '0;
        new_h2 = health2;
        if (hit1) new_h2 = (health2 > DMG) ? health2 - DMG : '0;

        cand1 = pos1;
        if (action1 == ACT_LEFT && pos1 != '0)       cand1 = pos1 - POS_W'(1);
        if (action1 == ACT_RIGHT && pos1 != POS_MAX) cand1 = pos1 + POS_W'(1);
        cand2 = pos2;
        if (action2 == ACT_LEFT && pos2 != '0)       cand2 = pos2 - POS_W'(1);
        if (action2 == ACT_RIGHT && pos2 != POS_MAX) cand2 = pos2 + POS_W'(1);

        // Any crossing or collision cancels both moves, keeping pos1 < pos2
        blocked = cand1 >= cand2;
        new_p1  = blocked ? pos1 : cand1;
        new_p2  = blocked ? pos2 : cand2;

        ko1        = new_h1 == '0;
        ko2        = new_h2 == '0;
        timeout    = turn_cnt == TICK_LAST;
        round_done = ko1 || ko2 || timeout;

        // KO takes priority; otherwise a timeout goes to the healthier player
        if (ko1 && ko2)         result = RES_DRAW;
        else if (ko2)           result = RES_P1;
        else if (ko1)           result = RES_P2;
        else if (new_h1 > new_h2) result = RES_P1;
        else if (new_h2 > new_h1) result = RES_P2;
        else                    result = RES_DRAW;
    end

    // Match FSM with all outputs registered
    always_ff @(posedge clk or negedge resetGame) begin
        if (!resetGame) begin
            state       <= StFight;
            health1     <= HEALTH_INIT;
            health2     <= HEALTH_INIT;
            pos1        <= '0;
            pos2        <= POS_MAX;
            turn_cnt    <= '0;
            hold_cnt    <= '0;
            roundWins1  <= '0;
            roundWins2  <= '0;
            roundResult <= '0;
            firstWin    <= 1'b0;
            secondWin   <= 1'b0;
            matchOver   <= 1'b0;
        end else begin
            unique case (state)
                StFight: begin
                    if (actionEnable) begin
                        health1  <= new_h1;
                        health2  <= new_h2;
                        pos1     <= new_p1;
                        pos2     <= new_p2;
                        turn_cnt <= turn_cnt + TICK_W'(1);
                        if (round_done) begin
                            roundResult <= result;
                            if (result == RES_P1) roundWins1 <= roundWins1 + 2'd1;
                            if (result == RES_P2) roundWins2 <= roundWins2 + 2'd1;
                            hold_cnt <= '0;
                            state    <= StRoundEnd;
                        end
                    end
                end
                StRoundEnd: begin
                    if (hold_cnt == HOLD_LAST) begin
                        if (roundWins1 == WINS_TARGET) begin
                            firstWin  <= 1'b1;
                            matchOver <= 1'b1;
                            state     <= StMatchOver;
                        end else if (roundWins2 == WINS_TARGET) begin
                            secondWin <= 1'b1;
                            matchOver <= 1'b1;
                            state     <= StMatchOver;
                        end else begin
                            health1  <= HEALTH_INIT;
                            health2  <= HEALTH_INIT;
                            pos1     <= '0;
                            pos2     <= POS_MAX;
                            turn_cnt <= '0;
                            state    <= StFight;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                StMatchOver: begin
                    state <= StMatchOver;
                end
                default: begin
                    state <= StFight;
                end
            endcase
        end
    end

endmodule

// File: doc/fighting_match_ctrl.md
FIGHTING_MATCH_CTRL -- requirements
Module: fighting_match_ctrl

Interface
REQ-001 SHALL take parameter HEALTH_W, default 2: width of each health counter.
REQ-002 SHALL take parameter MAX_HEALTH, default 3: health loaded at each round start; must be at most 2^HEALTH_W-1.
REQ-003 SHALL take parameter DAMAGE, default 1: health removed per landed attack.
REQ-004 SHALL take parameter ARENA_LEN, default 8: number of arena cells; POS_W = clog2(ARENA_LEN).
REQ-005 SHALL take parameter ROUNDS_TO_WIN, default 2: round wins needed to take the match; must be at most 3.
REQ-006 SHALL take parameter ROUND_TICKS, default 16: resolved turns per round before timeout.
REQ-007 SHALL take parameter END_HOLD, default 4: clk cycles spent in ROUND_END.
REQ-008 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-009 SHALL have port resetGame, input, 1 bit: reset, asynchronous, active-low.
REQ-010 SHALL have port actionEnable, input, 1 bit: turn strobe, sampled on clk; each high cycle is one turn.
REQ-011 SHALL have ports action1 and action2, input, 3 bits each: 000 idle, 001 left, 010 right, 011 attack, 100 defend; other codes are treated as idle.
REQ-012 SHALL have ports health1 and health2, output, HEALTH_W bits each: current health.
REQ-013 SHALL have ports pos1 and pos2, output, POS_W bits each: current cell.
REQ-014 SHALL have ports roundWins1 and roundWins2, output, 2 bits each: rounds won.
REQ-015 SHALL have ports firstWin and secondWin, output, 1 bit each: match winner flags.
REQ-016 SHALL have port roundResult, output, 2 bits: last round result; 00 none, 01 P1, 10 P2, 11 draw.
REQ-017 SHALL have port matchOver, output, 1 bit: high in state MATCH_OVER.

Function
REQ-018 SHALL implement the states FIGHT, ROUND_END and MATCH_OVER.
REQ-019 SHALL resolve a turn in FIGHT only, on a clk edge with actionEnable=1; all outputs update on that edge, giving 1-cycle latency.
REQ-020 SHALL evaluate attacks on pre-move positions: an attack hits only if pos2-pos1==1.
REQ-021 SHALL make a hit against a defending target do no damage.
REQ-022 SHALL apply damage as a saturating subtract, never below 0.
REQ-023 SHALL compute moves as candidates: left decrements, saturating at 0; right increments, saturating at ARENA_LEN-1.
REQ-024 SHALL require that P2 moving left decrements pos2 and P2 moving right increments pos2.
REQ-025 SHALL cancel both moves when the candidates give new1>=new2; otherwise both moves apply. Invariant: pos1<pos2 always.
REQ-026 SHALL process attack and move in the same turn, e.g. P1 attacks while P2 moves away: the hit lands on pre-move adjacency, then P2 moves.
REQ-027 SHALL count turns with a turn counter; the round times out on the ROUND_TICKS-th resolved turn.
REQ-028 SHALL end the round when a player's health reaches 0, with the other player winning the round.
REQ-029 SHALL score a draw when both players reach 0 in the same turn.
REQ-030 SHALL on timeout with neither player at 0 give the round to the higher health; equal health scores a draw.
REQ-031 SHALL give a KO priority over a timeout occurring in the same turn.
REQ-032 SHALL at round end set roundResult, increment the winner's roundWins (a draw increments neither), and enter ROUND_END.
REQ-033 SHALL ignore actionEnable in ROUND_END and MATCH_OVER.
REQ-034 SHALL leave ROUND_END after END_HOLD cycles: if a roundWins equals ROUNDS_TO_WIN, enter MATCH_OVER with firstWin or secondWin set.
REQ-035 SHALL otherwise leave ROUND_END by reloading health to MAX_HEALTH, pos1=0, pos2=ARENA_LEN-1 and turn counter=0, then return to FIGHT.
REQ-036 SHALL keep roundResult unchanged until the next round end.
REQ-037 SHALL never assert firstWin and secondWin together; MATCH_OVER holds until reset.

Reset
REQ-038 SHALL on resetGame=0 immediately set state=FIGHT, health=MAX_HEALTH for both players, pos1=0, pos2=ARENA_LEN-1, turn counter=0, roundWins=0, roundResult=00, firstWin=secondWin=matchOver=0.
REQ-039 SHALL apply reset regardless of state, including mid-ROUND_END and mid-turn.
REQ-040 SHALL take effect on the first rising clk edge after resetGame deasserts.

Verification
REQ-041 SHALL cover: defaults, P1 right x6 with P2 idle -> pos1 stops at 6; a 7th right gives pos1=6 (blocked).
REQ-042 SHALL cover: pos1=3/pos2=4, P1 attack with P2 defend -> health2 stays 3; P1 attack with P2 idle -> health2=2.
REQ-043 SHALL cover: pos1=3/pos2=5, both move toward each other -> both moves cancelled, pos1=3, pos2=5.
REQ-044 SHALL cover: adjacent, both at health 1, both attack -> roundResult=11, roundWins unchanged, new round after 4 cycles with health 3/3.
REQ-045 SHALL cover: P1 wins two KO rounds -> roundWins1=2, firstWin=1, matchOver=1; further actionEnable changes nothing.
REQ-046 SHALL cover: 16 idle turns -> timeout draw; resetGame pulsed in ROUND_END -> all reset values restored asynchronously.
